// File: rtl/cache_types.sv
// Shared types and geometry for the cache subsystem: adaptor FSM states and
// line/burst sizing used by cacheline_adaptor, cache_control and cache_datapath.
package cache_types;

  localparam int LINE_W   = 128;
  localparam int BURST_W  = 32;
  localparam int ADDR_W   = 16;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle around the line adaptor: cache-side pmem_* signals and memory-side mem_*
// burst signals. The adaptor uses the slave view; the cache/memory environment uses master.
interface cacheline_adaptor_if;
  import cache_types::*;

  logic [ADDR_W-1:0]  pmem_address;
  logic               pmem_read;
  logic               pmem_write;
  logic [LINE_W-1:0]  pmem_wdata;
  logic [LINE_W-1:0]  pmem_rdata;
  logic               pmem_resp;

  logic [ADDR_W-1:0]  mem_address;
  logic               mem_read;
  logic               mem_write;
  logic [BURST_W-1:0] mem_burst_o;
  logic [BURST_W-1:0] mem_burst_i;
  logic               mem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_burst_i, mem_resp,
    input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_burst_o
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_burst_i, mem_resp,
    output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_burst_o
  );

endinterface

// File: rtl/line_shift_reg.sv
// One cache line of storage: parallel load of a whole line, beat-indexed write
// of incoming burst data, and a beat-indexed read mux for outgoing bursts.
module line_shift_reg
  import cache_types::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [LINE_W-1:0]  load_data,
  input  logic               beat_we,
  input  logic [CNT_W-1:0]   beat_idx,
  input  logic [BURST_W-1:0] beat_wdata,
  output logic [LINE_W-1:0]  line,
  output logic [BURST_W-1:0] beat_rdata
);

  logic [LINE_W-1:0] line_q;

  // NOTE: the line buffer is reset on purpose -- pmem_rdata exposes it directly and must read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load) begin
      line_q <= load_data;
    end else if (beat_we) begin
      line_q[beat_idx*BURST_W +: BURST_W] <= beat_wdata;
    end
  end

  assign line       = line_q;
  assign beat_rdata = line_q[beat_idx*BURST_W +: BURST_W];

endmodule

// File: rtl/cacheline_adaptor.sv
// Bridges whole-line cache requests to a BEATS-beat burst memory port.
// Optional feature macro: ADAPTOR_PERF_EN adds saturating read/write line counters.
module cacheline_adaptor
  import cache_types::*;
(
  input  logic                clk,
  input  logic                rst_n,
  cacheline_adaptor_if.slave  bus
`ifdef ADAPTOR_PERF_EN
  ,
  output logic [15:0]         perf_rd_lines,
  output logic [15:0]         perf_wr_lines
`endif
);

  adaptor_state_t     state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  mem_address_q;
  logic [LINE_W-1:0]  line;
  logic [BURST_W-1:0] beat_rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.pmem_address[OFFSET_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state    = state;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    unique case (state)
      IDLE: begin
        // Read and write together is illegal; the write is the one honoured.
        if (bus.pmem_write)     next_state = WRITE;
        else if (bus.pmem_read) next_state = READ;
      end
      READ: begin
        bus.mem_read = 1'b1;
        if (bus.mem_resp && cnt == CNT_W'(BEATS - 1)) next_state = DONE;
      end
      WRITE: begin
        bus.mem_write = 1'b1;
        if (bus.mem_resp && cnt == CNT_W'(BEATS - 1)) next_state = DONE;
      end
      DONE: begin
        bus.pmem_resp = 1'b1;
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat counter wraps to 0 after the last beat; DONE clears it again for safety.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == READ || state == WRITE) && bus.mem_resp) begin
      cnt <= cnt + 1'b1;
    end else if (state == DONE) begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_address_q <= '0;
    end else if (state == IDLE && (bus.pmem_read || bus.pmem_write)) begin
      mem_address_q <= {bus.pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end
  end

  line_shift_reg u_line (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == IDLE && bus.pmem_write),
    .load_data  (bus.pmem_wdata),
    .beat_we    (state == READ && bus.mem_resp),
    .beat_idx   (cnt),
    .beat_wdata (bus.mem_burst_i),
    .line       (line),
    .beat_rdata (beat_rdata)
  );

  assign bus.mem_address = mem_address_q;
  assign bus.pmem_rdata  = line;
  assign bus.mem_burst_o = beat_rdata;

  always @(posedge clk) begin
    if (rst_n && state == IDLE)
      assert (!(bus.pmem_read && bus.pmem_write))
        else $warning("cacheline_adaptor: pmem_read and pmem_write both high in IDLE, write taken");
  end

`ifdef ADAPTOR_PERF_EN
  logic        is_write_q;
  logic [15:0] perf_rd_q, perf_wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_write_q <= 1'b0;
      perf_rd_q  <= '0;
      perf_wr_q  <= '0;
    end else begin
      if (state == IDLE) is_write_q <= bus.pmem_write;
      if (state == DONE) begin
        if (is_write_q) begin
          if (perf_wr_q != 16'hFFFF) perf_wr_q <= perf_wr_q + 16'd1;
        end else begin
          if (perf_rd_q != 16'hFFFF) perf_rd_q <= perf_rd_q + 16'd1;
        end
      end
    end
  end

  assign perf_rd_lines = perf_rd_q;
  assign perf_wr_lines = perf_wr_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: behavioural burst memory plus scoreboard queues
// for read lines and write beats; define ADAPTOR_PERF_EN to also exercise the counters.
module tb_cacheline_adaptor;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();

`ifdef ADAPTOR_PERF_EN
  logic [15:0] perf_rd_lines, perf_wr_lines;
`endif

  cacheline_adaptor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ADAPTOR_PERF_EN
    ,
    .perf_rd_lines (perf_rd_lines),
    .perf_wr_lines (perf_wr_lines)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [BURST_W-1:0] wr_exp[$];
  logic [LINE_W-1:0]  rd_exp[$];

  logic [31:0] rd_base    = 32'h0;
  int          stall_beat = 0;
  int          stall_cfg  = 0;
  int          stall_used = 0;
  int          mem_beat   = 0;
  logic        force_resp = 1'b0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Burst memory: answers in the same cycle unless a stall is configured for one beat.
  always @(negedge clk) begin
    bus.mem_resp = 1'b0;
    if (bus.mem_read || bus.mem_write) begin
      if (bus.mem_write) begin
        if (wr_exp.size() == 0) check("wr_unexpected_beat", 1, 0);
        else                    check("mem_burst_o", bus.mem_burst_o, wr_exp[0]);
      end
      if (mem_beat == stall_beat && stall_used < stall_cfg) begin
        stall_used++;
      end else begin
        bus.mem_resp = 1'b1;
        if (bus.mem_read) bus.mem_burst_i = rd_base + 32'(mem_beat);
        if (bus.mem_write && wr_exp.size() != 0) void'(wr_exp.pop_front());
        mem_beat++;
      end
    end else begin
      mem_beat     = 0;
      stall_used   = 0;
      bus.mem_resp = force_resp;
    end
  end

  task automatic run_op(input bit do_read, input bit do_write, input logic [15:0] addr,
                        input logic [LINE_W-1:0] wdata, input int exp_lat);
    int lat = -1;
    bit got = 0;
    logic [LINE_W-1:0] line_seen;
    @(negedge clk);
    bus.pmem_address = addr;
    bus.pmem_wdata   = wdata;
    bus.pmem_read    = do_read;
    bus.pmem_write   = do_write;
    if (do_write) for (int i = 0; i < BEATS; i++) wr_exp.push_back(wdata[i*BURST_W +: BURST_W]);
    else          rd_exp.push_back(line_of(rd_base));
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("mem_address", bus.mem_address, {addr[15:4], 4'h0});
        check("mem_read_level", bus.mem_read, !do_write);
        check("mem_write_level", bus.mem_write, do_write);
      end
      if (bus.pmem_resp) begin
        got = 1;
        lat = c;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
      end
    end
    if (!got) begin
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;
    end
    check("pmem_resp_latency", lat, exp_lat);
    line_seen = bus.pmem_rdata;
    if (!do_write && got && rd_exp.size() != 0) check("pmem_rdata", line_seen, rd_exp.pop_front());
    @(negedge clk);
    check("pmem_resp_single_pulse", bus.pmem_resp, 0);
    if (!do_write) check("pmem_rdata_held", bus.pmem_rdata, line_seen);
    else           check("write_beats_consumed", wr_exp.size(), 0);
  endtask

  initial begin
    // 1: reset holds everything quiet even with a request pending
    rst_n            = 1'b0;
    bus.pmem_read    = 1'b1;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 16'h1237;
    bus.pmem_wdata   = '0;
    bus.mem_burst_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_read", bus.mem_read, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_pmem_resp", bus.pmem_resp, 0);
    check("rst_pmem_rdata", bus.pmem_rdata, 0);
    check("rst_mem_address", bus.mem_address, 0);
    bus.pmem_read = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);

    // 2: zero-stall read
    rd_base = 32'hA0A0_0000;
    run_op(1, 0, 16'h1237, '0, 5);
    check("t2_line", bus.pmem_rdata, 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000);

    // 3: write with a two-cycle stall on beat 1
    stall_beat = 1;
    stall_cfg  = 2;
    run_op(0, 1, 16'h4F00, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 7);
    stall_cfg  = 0;

    // 4: reset after three beats of a read aborts it silently
    rd_base = 32'hB0B0_0000;
    @(negedge clk);
    bus.pmem_address = 16'h2000;
    bus.pmem_read    = 1'b1;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_read_async", bus.mem_read, 0);
    check("abort_pmem_resp", bus.pmem_resp, 0);
    bus.pmem_read = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", bus.pmem_resp, 0);
    end
    check("abort_rdata_cleared", bus.pmem_rdata, 0);
    rd_base = 32'hC0C0_0000;
    run_op(1, 0, 16'h2010, '0, 5);

    // 5: simultaneous read/write performs the write; spurious mem_resp in IDLE is ignored
    run_op(1, 1, 16'h5555, 128'hDEAD_BEEF_0BAD_F00D_1111_2222_3333_4444, 5);
    check("both_req_line_loaded", bus.pmem_rdata, 128'hDEAD_BEEF_0BAD_F00D_1111_2222_3333_4444);
    @(negedge clk);
    #1 force_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spurious_mem_read", bus.mem_read, 0);
      check("spurious_pmem_resp", bus.pmem_resp, 0);
    end
    #1 force_resp = 1'b0;
    check("spurious_rdata_kept", bus.pmem_rdata, 128'hDEAD_BEEF_0BAD_F00D_1111_2222_3333_4444);
    rd_base = 32'hD0D0_0000;
    run_op(1, 0, 16'h6030, '0, 5);

`ifdef ADAPTOR_PERF_EN
    // 6: performance counters
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("perf_rd_reset", perf_rd_lines, 0);
    for (int i = 0; i < 3; i++) begin
      rd_base = 32'hE000_0000 + 32'(i * 16);
      run_op(1, 0, 16'h7000 + 16'(i * 16), '0, 5);
    end
    for (int i = 0; i < 2; i++) run_op(0, 1, 16'h8000, {4{32'h5A5A_0000 + 32'(i)}}, 5);
    check("perf_rd_lines", perf_rd_lines, 3);
    check("perf_wr_lines", perf_wr_lines, 2);
    force dut.perf_rd_q = 16'hFFFF;
    @(negedge clk);
    release dut.perf_rd_q;
    rd_base = 32'hF000_0000;
    run_op(1, 0, 16'h9000, '0, 5);
    check("perf_rd_saturate", perf_rd_lines, 16'hFFFF);
    check("perf_wr_unchanged", perf_wr_lines, 2);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
